clv_sequencer: RTL and testbench
================================

# clv_sequencer

Block-level controller for one DEFLATE dynamic-Huffman block. It sequences the frequency histogram stage, the `clv` code-length-value engine (run twice: literal/length tree, then distance tree), canonical code assignment and the encoder stage. Each stage is driven over a start-pulse/done-pulse handshake, and every stage has a watchdog timeout. The block sits between the top-level compressor control and the stage datapaths; stored blocks bypass the tree stages.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 65536: maximum cycles a stage may run before an error is declared.
- `TO_W`, 17: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.
- `CNT_W`, 32: width of the block cycle counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `blk_start` in 1: begin a block; sampled only in IDLE.
- `blk_stored` in 1: sampled with `blk_start`; 1 = stored block, which skips CLV/CANON.
- `blk_abort` in 1: synchronous abort, honoured in any state.
- `blk_busy` out 1: high in every state except IDLE.
- `blk_done` out 1: one-cycle pulse on successful completion.
- `blk_err` out 1: level, high in ERR.
- `err_stage` out 3: stage code that timed out.
- `blk_cycles` out CNT_W: latched cycle count of the last completed block.
- `hist_start`/`hist_done` out/in 1: histogram stage handshake.
- `clv_start`/`clv_done` out/in 1: clv engine handshake.
- `clv_tree_sel` out 1: 0 = literal/length tree, 1 = distance tree; held for the whole CLV stage.
- `canon_start`/`canon_done` out/in 1: canonical code stage handshake.
- `enc_start`/`enc_done` out/in 1: encoder stage handshake.
- `stage_abort` out 1: one-cycle pulse to all datapaths on abort or timeout.

## Operation
- States and stage codes:
  - IDLE = 0, HIST = 1, CLV_LIT = 2, CLV_DIST = 3, CANON = 4, ENC = 5, DONE = 6, ERR = 7.
- Dynamic block path: IDLE → HIST → CLV_LIT → CLV_DIST → CANON → ENC → DONE → IDLE.
- Stored block path: IDLE → HIST → ENC → DONE → IDLE.
- Stored flag: latched from `blk_stored` at accept; it is not re-sampled later.
- Stage entry:
  - The matching `*_start` pulses high for exactly the first cycle in the state.
  - The watchdog clears to 0.
  - `clv_tree_sel` = 1 only in CLV_DIST.
- Done handling:
  - A `*_done` seen in the start cycle is ignored.
  - From the next cycle on, the first `*_done` advances the state.
  - `done` inputs belonging to other stages are ignored.
- Timeout:
  - The watchdog increments each cycle in a stage state.
  - If it reaches TIMEOUT_CYCLES−1 with no `done`, the next state is ERR.
  - On that transition: `err_stage` ← current state code, and `stage_abort` pulses.
  - If `done` and the timeout coincide, `done` wins.
- ERR: sticky. Leaves only via `blk_abort` (→ IDLE, `err_stage` kept) or reset. `blk_start` is ignored in ERR.
- `blk_abort`:
  - Takes priority over every other event.
  - From any non-IDLE, non-ERR state: → IDLE, `stage_abort` pulses, no `blk_done`, `blk_cycles` unchanged.
  - In IDLE: no effect.
- Cycle counter:
  - Clears on block accept, increments every busy cycle.
  - Copied to `blk_cycles` on entry to DONE.
- DONE: lasts one cycle with `blk_done` = 1, then IDLE. `blk_start` in that cycle is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0.
- Accept: `blk_start` high at edge N in IDLE → state HIST at N+1, `hist_start` high during cycle N+1, `blk_busy` high from N+1.
- Handoff: `done` sampled at edge M → next stage `*_start` high during cycle M+1. This is one cycle of controller overhead per stage.
- Minimum block latency (every `done` arrives in the cycle after its start): dynamic = 11 cycles from accept to `blk_done`, stored = 5.
- `blk_cycles` = number of busy cycles, including the DONE cycle.
- Reset mid-block: all outputs return to 0 immediately (asynchronous); no `stage_abort` pulse is issued.

## Structure
- Shared package `deflate_pkg` holds:
  - the state/stage-code enum (3 bits);
  - the `TIMEOUT_CYCLES` default.
  - `err_stage` encoding is reused by the top-level status register.
- One sub-module, `stage_watchdog`:
  - inputs: clear, enable;
  - output: expired;
  - parameters: TIMEOUT_CYCLES, TO_W.
- All other logic is a single FSM with registered outputs.

## Test plan
- Dynamic block, every `done` one cycle after its start → start order hist, clv(sel 0), clv(sel 1), canon, enc; `blk_done` 11 cycles after accept; `blk_cycles` = 11.
- Stored block → `clv_start` and `canon_start` never assert; `blk_done` 5 cycles after accept.
- `clv_done` withheld in CLV_DIST, TIMEOUT_CYCLES = 16 → ERR after 16 cycles; `err_stage` = 3; one `stage_abort` pulse; a following `blk_start` is ignored; `blk_abort` → IDLE.
- `blk_abort` asserted mid-CANON in the same cycle as `canon_done` → IDLE; `stage_abort` pulses; no `enc_start`, no `blk_done`.
- `hist_done` asserted in the same cycle as `hist_start`, then again 3 cycles later → only the second `done` advances; a stray `enc_done` during HIST is ignored.
- `reset` low mid-ENC → all outputs 0 asynchronously; after release, a new dynamic block completes normally.

Source files
------------

// File: rtl/deflate_pkg.sv
// Shared definitions for the DEFLATE block controller: state/stage codes and
// the default stage watchdog limit.
package deflate_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HIST     = 3'd1,
    ST_CLV_LIT  = 3'd2,
    ST_CLV_DIST = 3'd3,
    ST_CANON    = 3'd4,
    ST_ENC      = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } stage_e;

  localparam int DEF_TIMEOUT_CYCLES = 65536;

  // True for the states that run a datapath stage under the watchdog.
  function automatic logic is_stage_state(input stage_e s);
    return (s == ST_HIST) || (s == ST_CLV_LIT) || (s == ST_CLV_DIST) ||
           (s == ST_CANON) || (s == ST_ENC);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage cycle watchdog. 'clear' marks the first cycle of a stage, which
// counts as cycle 0; 'expired' flags the last permitted cycle.
module stage_watchdog
  import deflate_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = 17
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_count;
  logic [TO_W-1:0] w_count;

  assign w_count = clear ? {TO_W{1'b0}} : r_count;
  assign expired = enable && (w_count == LAST);

  // Count cycles spent in the current stage; idle states park the counter at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {TO_W{1'b0}};
    end else if (enable) begin
      r_count <= w_count + TO_W'(1);
    end else begin
      r_count <= {TO_W{1'b0}};
    end
  end

endmodule

// File: rtl/clv_sequencer.sv
// Block-level controller for one DEFLATE dynamic-Huffman block: sequences
// histogram, two clv passes, canonical coding and encoding with a watchdog.
module clv_sequencer
  import deflate_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = 17,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             blk_start,
  input  logic             blk_stored,
  input  logic             blk_abort,
  output logic             blk_busy,
  output logic             blk_done,
  output logic             blk_err,
  output logic [2:0]       err_stage,
  output logic [CNT_W-1:0] blk_cycles,
  output logic             hist_start,
  input  logic             hist_done,
  output logic             clv_start,
  input  logic             clv_done,
  output logic             clv_tree_sel,
  output logic             canon_start,
  input  logic             canon_done,
  output logic             enc_start,
  input  logic             enc_done,
  output logic             stage_abort
);

  stage_e           r_state;
  logic             r_first;
  logic             r_stored;
  logic [CNT_W-1:0] r_cyc;

  stage_e w_next;
  stage_e w_succ;
  logic   w_done;
  logic   w_expired;
  logic   w_in_stage;
  logic   w_timeout;
  logic   w_kill;
  logic   w_accept;
  logic   w_enter;

  assign w_in_stage = is_stage_state(r_state);
  assign w_enter    = (w_next != r_state);

  stage_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (r_first),
    .enable (w_in_stage),
    .expired(w_expired)
  );

  // Select the done input owned by the current stage; the start cycle is blind.
  always_comb begin
    w_done = 1'b0;
    case (r_state)
      ST_HIST:                 w_done = hist_done;
      ST_CLV_LIT, ST_CLV_DIST: w_done = clv_done;
      ST_CANON:                w_done = canon_done;
      ST_ENC:                  w_done = enc_done;
      default:                 w_done = 1'b0;
    endcase
    w_done = w_done & ~r_first;
  end

  // Successor of each stage; stored blocks jump from histogram straight to encode.
  always_comb begin
    w_succ = ST_IDLE;
    case (r_state)
      ST_HIST:     w_succ = r_stored ? ST_ENC : ST_CLV_LIT;
      ST_CLV_LIT:  w_succ = ST_CLV_DIST;
      ST_CLV_DIST: w_succ = ST_CANON;
      ST_CANON:    w_succ = ST_ENC;
      ST_ENC:      w_succ = ST_DONE;
      default:     w_succ = ST_IDLE;
    endcase
  end

  // Next-state decision: abort first, then done, then watchdog expiry.
  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    w_kill    = 1'b0;
    w_accept  = 1'b0;
    if (blk_abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
      w_kill = (r_state != ST_ERR);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (blk_start) begin
            w_next   = ST_HIST;
            w_accept = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
        ST_HIST, ST_CLV_LIT, ST_CLV_DIST, ST_CANON, ST_ENC: begin
          if (w_done) begin
            w_next = w_succ;
          end else if (w_expired) begin
            w_next    = ST_ERR;
            w_timeout = 1'b1;
            w_kill    = 1'b1;
          end else begin
            w_next = r_state;
          end
        end
        ST_DONE: w_next = ST_IDLE;
        ST_ERR:  w_next = ST_ERR;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // State register and all registered outputs, derived from the chosen next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_first      <= 1'b0;
      r_stored     <= 1'b0;
      r_cyc        <= {CNT_W{1'b0}};
      blk_busy     <= 1'b0;
      blk_done     <= 1'b0;
      blk_err      <= 1'b0;
      err_stage    <= 3'd0;
      blk_cycles   <= {CNT_W{1'b0}};
      hist_start   <= 1'b0;
      clv_start    <= 1'b0;
      clv_tree_sel <= 1'b0;
      canon_start  <= 1'b0;
      enc_start    <= 1'b0;
      stage_abort  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_first      <= w_enter && is_stage_state(w_next);
      hist_start   <= w_enter && (w_next == ST_HIST);
      clv_start    <= w_enter && ((w_next == ST_CLV_LIT) || (w_next == ST_CLV_DIST));
      clv_tree_sel <= (w_next == ST_CLV_DIST);
      canon_start  <= w_enter && (w_next == ST_CANON);
      enc_start    <= w_enter && (w_next == ST_ENC);
      blk_busy     <= (w_next != ST_IDLE);
      blk_done     <= (w_next == ST_DONE);
      blk_err      <= (w_next == ST_ERR);
      stage_abort  <= w_kill;
      if (w_timeout) begin
        err_stage <= r_state;
      end
      // The accept cycle's successor (first HIST cycle) is already busy cycle 1.
      if (w_accept) begin
        r_cyc    <= CNT_W'(1);
        r_stored <= blk_stored;
      end else if (r_state != ST_IDLE) begin
        r_cyc <= r_cyc + CNT_W'(1);
      end
      if ((w_next == ST_DONE) && (r_state == ST_ENC)) begin
        blk_cycles <= r_cyc + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_clv_sequencer.sv
// Self-checking bench for clv_sequencer: a scoreboard of expected start/done/abort
// events with their cycle stamps, plus per-scenario status checks.
module tb_clv_sequencer;

  localparam int TO    = 16;
  localparam int CNT_W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic blk_start = 1'b0, blk_stored = 1'b0, blk_abort = 1'b0;
  logic blk_busy, blk_done, blk_err, stage_abort;
  logic [2:0] err_stage;
  logic [CNT_W-1:0] blk_cycles;
  logic hist_start, clv_start, clv_tree_sel, canon_start, enc_start;
  logic hist_done, clv_done, canon_done, enc_done;

  logic m_hist_done = 1'b0, m_clv_done = 1'b0, m_canon_done = 1'b0, m_enc_done = 1'b0;
  logic a_hist = 1'b0, a_clv = 1'b0, a_canon = 1'b0, a_enc = 1'b0;
  logic s_hist = 1'b0, s_cl = 1'b0, s_cd = 1'b0, s_canon = 1'b0, s_enc = 1'b0;
  logic [4:0] auto_en = 5'b00000;

  assign hist_done  = m_hist_done | a_hist;
  assign clv_done   = m_clv_done | a_clv;
  assign canon_done = m_canon_done | a_canon;
  assign enc_done   = m_enc_done | a_enc;

  typedef struct {
    int code;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] mon_ev;
  ev_t mon_e;

  clv_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .blk_stored(blk_stored),
    .blk_abort(blk_abort), .blk_busy(blk_busy), .blk_done(blk_done), .blk_err(blk_err),
    .err_stage(err_stage), .blk_cycles(blk_cycles), .hist_start(hist_start),
    .hist_done(hist_done), .clv_start(clv_start), .clv_done(clv_done),
    .clv_tree_sel(clv_tree_sel), .canon_start(canon_start), .canon_done(canon_done),
    .enc_start(enc_start), .enc_done(enc_done), .stage_abort(stage_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Auto responder: raise a stage's done exactly one cycle after its start.
  always @(negedge clk) begin
    a_hist  = s_hist;
    a_clv   = s_cl | s_cd;
    a_canon = s_canon;
    a_enc   = s_enc;
    s_hist  = auto_en[0] & hist_start;
    s_cl    = auto_en[1] & clv_start & ~clv_tree_sel;
    s_cd    = auto_en[2] & clv_start & clv_tree_sel;
    s_canon = auto_en[3] & canon_start;
    s_enc   = auto_en[4] & enc_start;
  end

  // Scoreboard: every observed event pops the next expected (code, cycle).
  // Codes: 1 hist, 2 clv lit, 3 clv dist, 4 canon, 5 enc, 6 blk_done, 7 stage_abort.
  always @(negedge clk) begin
    mon_ev = {stage_abort, blk_done, enc_start, canon_start,
              clv_start & clv_tree_sel, clv_start & ~clv_tree_sel, hist_start, 1'b0};
    for (int i = 1; i < 8; i++) begin
      if (mon_ev[i]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL event_unexpected got code=%0d cyc=%0d, expected none", i, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.code !== i || mon_e.cyc !== cyc) begin
            errors++;
            $display("FAIL event got code=%0d cyc=%0d, expected code=%0d cyc=%0d",
                     i, cyc, mon_e.code, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic push(input int code, input int t);
    exp_q.push_back('{code: code, cyc: t});
  endtask

  task automatic pulse_start(input logic stored);
    blk_start  = 1'b1;
    blk_stored = stored;
    @(negedge clk);
    blk_start  = 1'b0;
    blk_stored = 1'b0;
  endtask

  task automatic drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_events got %0d pending, expected 0 (next code=%0d cyc=%0d)",
               name, exp_q.size(), exp_q[0].code, exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({blk_busy, blk_done, blk_err, err_stage, hist_start, clv_start, clv_tree_sel,
         canon_start, enc_start, stage_abort, blk_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b err=%b err_stage=%0d cycles=%0d, expected all 0",
               blk_busy, blk_err, err_stage, blk_cycles);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (blk_busy !== 1'b0 || blk_cycles !== 32'd0) begin
      errors++;
      $display("FAIL post_reset_idle got busy=%b cycles=%0d, expected 0 0", blk_busy, blk_cycles);
    end
  endtask

  task automatic test_dynamic();
    int a;
    auto_en = 5'b11111;
    a = cyc + 1;
    push(1, a); push(2, a + 2); push(3, a + 4); push(4, a + 6); push(5, a + 8); push(6, a + 10);
    pulse_start(1'b0);
    for (int k = 0; k < 12; k++) begin
      if (cyc == a + 3) begin
        checks++;
        if (clv_tree_sel !== 1'b0 || blk_busy !== 1'b1) begin
          errors++;
          $display("FAIL dyn_sel_lit got sel=%b busy=%b, expected 0 1", clv_tree_sel, blk_busy);
        end
      end
      if (cyc == a + 5) begin
        checks++;
        if (clv_tree_sel !== 1'b1) begin
          errors++;
          $display("FAIL dyn_sel_dist got %b, expected 1", clv_tree_sel);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (blk_cycles !== 32'd11 || blk_busy !== 1'b0) begin
      errors++;
      $display("FAIL dyn_cycles got cycles=%0d busy=%b, expected 11 0", blk_cycles, blk_busy);
    end
    drained("dynamic");
  endtask

  task automatic test_stored();
    int a;
    auto_en = 5'b11111;
    a = cyc + 1;
    push(1, a); push(5, a + 2); push(6, a + 4);
    pulse_start(1'b1);
    repeat (6) @(negedge clk);
    checks++;
    if (blk_cycles !== 32'd5 || blk_busy !== 1'b0) begin
      errors++;
      $display("FAIL stored_cycles got cycles=%0d busy=%b, expected 5 0", blk_cycles, blk_busy);
    end
    drained("stored");
  endtask

  task automatic test_hist_done_timing();
    int a;
    auto_en = 5'b10000;
    a = cyc + 1;
    push(1, a); push(5, a + 4); push(6, a + 6);
    pulse_start(1'b1);
    m_hist_done = 1'b1;
    @(negedge clk);
    m_hist_done = 1'b0;
    m_enc_done  = 1'b1;
    @(negedge clk);
    m_enc_done = 1'b0;
    checks++;
    if (blk_busy !== 1'b1 || hist_start !== 1'b0) begin
      errors++;
      $display("FAIL hist_stays got busy=%b, expected 1", blk_busy);
    end
    @(negedge clk);
    m_hist_done = 1'b1;
    @(negedge clk);
    m_hist_done = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (blk_cycles !== 32'd7) begin
      errors++;
      $display("FAIL hist_cycles got %0d, expected 7", blk_cycles);
    end
    drained("hist_timing");
  endtask

  task automatic test_abort_canon();
    int a;
    auto_en = 5'b00111;
    a = cyc + 1;
    push(1, a); push(2, a + 2); push(3, a + 4); push(4, a + 6); push(7, a + 9);
    pulse_start(1'b0);
    repeat (8) @(negedge clk);
    m_canon_done = 1'b1;
    blk_abort    = 1'b1;
    @(negedge clk);
    m_canon_done = 1'b0;
    blk_abort    = 1'b0;
    checks++;
    if (blk_busy !== 1'b0 || blk_cycles !== 32'd7 || blk_err !== 1'b0) begin
      errors++;
      $display("FAIL abort_canon got busy=%b cycles=%0d err=%b, expected 0 7 0",
               blk_busy, blk_cycles, blk_err);
    end
    repeat (3) @(negedge clk);
    drained("abort_canon");
  endtask

  task automatic test_timeout_err();
    int a;
    auto_en = 5'b11011;
    a = cyc + 1;
    push(1, a); push(2, a + 2); push(3, a + 4); push(7, a + 4 + TO);
    pulse_start(1'b0);
    repeat (4 + TO) @(negedge clk);
    checks++;
    if (blk_err !== 1'b1 || err_stage !== 3'd3 || blk_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_err got err=%b stage=%0d busy=%b, expected 1 3 1",
               blk_err, err_stage, blk_busy);
    end
    blk_start = 1'b1;
    repeat (2) @(negedge clk);
    blk_start = 1'b0;
    @(negedge clk);
    checks++;
    if (blk_err !== 1'b1 || blk_busy !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got err=%b busy=%b, expected 1 1", blk_err, blk_busy);
    end
    blk_abort = 1'b1;
    @(negedge clk);
    blk_abort = 1'b0;
    checks++;
    if (blk_err !== 1'b0 || blk_busy !== 1'b0 || err_stage !== 3'd3 || blk_cycles !== 32'd7) begin
      errors++;
      $display("FAIL err_abort got err=%b busy=%b stage=%0d cycles=%0d, expected 0 0 3 7",
               blk_err, blk_busy, err_stage, blk_cycles);
    end
    repeat (2) @(negedge clk);
    drained("timeout");
  endtask

  task automatic test_reset_mid_enc();
    int a;
    auto_en = 5'b01111;
    a = cyc + 1;
    push(1, a); push(2, a + 2); push(3, a + 4); push(4, a + 6); push(5, a + 8);
    pulse_start(1'b0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({blk_busy, blk_done, blk_err, err_stage, hist_start, clv_start, clv_tree_sel,
         canon_start, enc_start, stage_abort, blk_cycles} !== '0) begin
      errors++;
      $display("FAIL async_reset got busy=%b err_stage=%0d cycles=%0d, expected all 0",
               blk_busy, err_stage, blk_cycles);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drained("reset_mid_enc");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_dynamic();
    test_stored();
    test_hist_done_timing();
    test_abort_canon();
    test_timeout_err();
    test_reset_mid_enc();
    test_dynamic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got no completion, expected finish before 100000");
    $fatal(1);
  end

endmodule
